instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: PC_WIDTH, 8, width of program counter and instruction memory address.
REQ-002 Parameter: RESET_PC, 8'h00, PC value loaded on reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 memReq  output  1  instruction memory read request.
REQ-006 memAddr  output  PC_WIDTH  instruction memory word address.
REQ-007 memAck  input  1  memory read complete; memData valid this cycle.
REQ-008 memData  input  16  instruction word returned by memory.
REQ-009 stall  input  1  decode/control stage cannot accept a new instruction.
REQ-010 branchTaken  input  1  redirect fetch to branchTarget.
REQ-011 branchTarget  input  PC_WIDTH  redirect address.
REQ-012 instrValid  output  1  instruction register holds a valid instruction.
REQ-013 opcode  output  5  IR[15:11], feeds control unit opcode input.
REQ-014 rd  output  3  IR[10:8], destination register.
REQ-015 rs  output  3  IR[7:5], source register.
REQ-016 funct  output  4  IR[3:0], R-type function code; IR[4] reserved, ignored.
REQ-017 pc  output  PC_WIDTH  address of the instruction currently in IR.

Function
REQ-018 FSM states IDLE, REQ, VALID; one-hot or binary encoding at implementer's choice.
REQ-019 IDLE: memReq=0, instrValid=0; unconditionally -> REQ next cycle.
REQ-020 REQ: memReq=1, memAddr=fetchPC; memReq and memAddr held stable until memAck or branchTaken.
REQ-021 REQ with memAck=1 and branchTaken=0: IR<=memData, pc<=fetchPC, fetchPC<=fetchPC+1, -> VALID; instrValid=1 from next cycle.
REQ-022 Fetch latency: memAck in cycle N -> opcode/rd/rs/funct/instrValid valid in cycle N+1.
REQ-023 VALID with stall=1: IR, pc, instrValid held; memReq=0.
REQ-024 VALID with stall=0: instruction consumed this cycle; -> REQ, instrValid=0 next cycle.
REQ-025 branchTaken=1 in any state: fetchPC<=branchTarget, instrValid<=0, -> REQ; overrides stall and memAck (memData that cycle discarded, IR unchanged).
REQ-026 fetchPC increment wraps modulo 2^PC_WIDTH (8'hFF -> 8'h00), no flag.
REQ-027 memAck outside REQ state ignored.
REQ-028 Decoded field outputs driven combinationally from IR only; no path from memData to outputs.

Reset
REQ-029 RST=1 asynchronously forces: state=IDLE, fetchPC=RESET_PC, pc=RESET_PC, IR=16'h0000, instrValid=0, memReq=0, memAddr=RESET_PC.
REQ-030 Reset asserted mid-request abandons the request; a memAck arriving while RST=1 or in the first cycle after release is ignored.
REQ-031 First memReq asserted the second rising edge after RST deasserts (IDLE then REQ).

Verification
REQ-032 Reset release, memAck one cycle after each memReq, memory[0]=16'h1000, stall=0 -> memAddr=00 requested, opcode=5'b00010 (AR), instrValid=1 one cycle after ack, pc=00; next request memAddr=01.
REQ-033 memory[1]=16'h5A05 fetched, stall=1 for 4 cycles -> instrValid,opcode=5'b01011,rd=3'b010,funct=4'b0101 held 4 cycles, memReq=0 throughout; request for 02 issued only after stall falls.
REQ-034 memAck delayed 3 cycles -> memReq=1 and memAddr constant for all 4 cycles, instrValid=0 until cycle after ack.
REQ-035 branchTaken=1, branchTarget=8'h40 in same cycle as memAck -> memData discarded, instrValid=0, next memAddr=8'h40; after ack pc=8'h40.
REQ-036 RESET_PC=8'hFF, fetch two instructions -> pc=FF then 00, memAddr wraps to 00 with no error.
REQ-037 RST pulsed while in REQ with memAck arriving same cycle -> all outputs at reset values, IR=0, instrValid=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: IDLE/REQ/VALID fetch FSM driving memReq/memAddr, latching memData into IR on memAck, decoding opcode/rd/rs/funct and pc, with stall hold and branch redirect
module instr_fetch #(
  parameter int PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                memReq,
  output logic [PC_WIDTH-1:0] memAddr,
  input  logic                memAck,
  input  logic [15:0]         memData,
  input  logic                stall,
  input  logic                branchTaken,
  input  logic [PC_WIDTH-1:0] branchTarget,
  output logic                instrValid,
  output logic [4:0]          opcode,
  output logic [2:0]          rd,
  output logic [2:0]          rs,
  output logic [3:0]          funct,
  output logic [PC_WIDTH-1:0] pc
);
  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;
  state_t state, state_n;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [15:0] ir;
  logic load;
  logic unused_ir4;
  always_comb begin
    state_n = state;
    load = state == REQ && memAck && !branchTaken;
    state_n = branchTaken ? REQ :
              state == IDLE ? REQ :
              state == REQ ? (memAck ? VALID : REQ) :
              (stall ? VALID : REQ);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      state <= state_n;
      if (branchTaken) fetch_pc <= branchTarget;
      else if (load) fetch_pc <= fetch_pc + PC_WIDTH'(1);
      if (load) begin
        ir <= memData;
        pc <= fetch_pc;
      end
    end
  end
  assign memReq = state == REQ;
  assign memAddr = fetch_pc;
  assign instrValid = state == VALID;
  assign opcode = ir[15:11];
  assign rd = ir[10:8];
  assign rs = ir[7:5];
  assign funct = ir[3:0];
  assign unused_ir4 = ir[4];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch (default RESET_PC and RESET_PC=FF wrap instance)
module tb_instr_fetch;
  logic CLK = 0;
  logic RST, memAck, stall, branchTaken;
  logic [15:0] memData;
  logic [7:0] branchTarget;
  logic memReq, instrValid;
  logic [7:0] memAddr, pc;
  logic [4:0] opcode;
  logic [2:0] rd, rs;
  logic [3:0] funct;
  logic rst1, ack1, stall1, br1;
  logic [15:0] data1;
  logic [7:0] tgt1;
  logic req1, valid1;
  logic [7:0] addr1, pc1;
  logic [4:0] opcode1;
  logic [2:0] rd1, rs1;
  logic [3:0] funct1;
  int errors = 0, checks = 0;
  always #5 CLK = ~CLK;
  instr_fetch dut (
    .CLK(CLK), .RST(RST), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
    .memData(memData), .stall(stall), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .instrValid(instrValid), .opcode(opcode), .rd(rd), .rs(rs), .funct(funct), .pc(pc)
  );
  instr_fetch #(.PC_WIDTH(8), .RESET_PC(8'hFF)) dut_ff (
    .CLK(CLK), .RST(rst1), .memReq(req1), .memAddr(addr1), .memAck(ack1),
    .memData(data1), .stall(stall1), .branchTaken(br1), .branchTarget(tgt1),
    .instrValid(valid1), .opcode(opcode1), .rd(rd1), .rs(rs1), .funct(funct1), .pc(pc1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RST = 1; memAck = 1; memData = 16'hFFFF; stall = 0; branchTaken = 0; branchTarget = 0;
    rst1 = 1; ack1 = 0; data1 = 0; stall1 = 0; br1 = 0; tgt1 = 0;
    step; step;
    chk("rst_req", memReq, 0);
    chk("rst_addr", memAddr, 8'h00);
    chk("rst_valid", instrValid, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_funct", funct, 0);
    RST = 0;
    chk("idle_req", memReq, 0);
    step;
    chk("first_req", memReq, 1);
    chk("first_addr", memAddr, 8'h00);
    chk("ack_in_idle_ignored", instrValid, 0);
    memAck = 0;
    step;
    chk("wait_req", memReq, 1);
    memAck = 1; memData = 16'h1000;
    step;
    memAck = 0;
    chk("f0_valid", instrValid, 1);
    chk("f0_opcode", opcode, 5'b00010);
    chk("f0_pc", pc, 8'h00);
    chk("f0_req", memReq, 0);
    step;
    chk("f1_addr", memAddr, 8'h01);
    chk("f1_req", memReq, 1);
    chk("f1_valid", instrValid, 0);
    step;
    memAck = 1; memData = 16'h5A05; stall = 1;
    step;
    memAck = 1; memData = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", instrValid, 1);
      chk("stall_opcode", opcode, 5'b01011);
      chk("stall_rd", rd, 3'b010);
      chk("stall_rs", rs, 3'b000);
      chk("stall_funct", funct, 4'b0101);
      chk("stall_pc", pc, 8'h01);
      chk("stall_req", memReq, 0);
      step;
    end
    memAck = 0;
    chk("stall_hold_req", memReq, 0);
    stall = 0;
    step;
    chk("f2_req", memReq, 1);
    chk("f2_addr", memAddr, 8'h02);
    for (int i = 0; i < 3; i++) begin
      chk("slow_req", memReq, 1);
      chk("slow_addr", memAddr, 8'h02);
      chk("slow_valid", instrValid, 0);
      step;
    end
    chk("slow_req4", memReq, 1);
    chk("slow_addr4", memAddr, 8'h02);
    memAck = 1; memData = 16'h8923;
    step;
    memAck = 0;
    chk("slow_valid_after", instrValid, 1);
    chk("slow_pc", pc, 8'h02);
    chk("slow_opcode", opcode, 5'h11);
    chk("slow_rd", rd, 3'b001);
    chk("slow_rs", rs, 3'b001);
    chk("slow_funct", funct, 4'b0011);
    step;
    chk("f3_addr", memAddr, 8'h03);
    memAck = 1; memData = 16'hFFFF; branchTaken = 1; branchTarget = 8'h40;
    step;
    branchTaken = 0; memAck = 0;
    chk("br_valid", instrValid, 0);
    chk("br_req", memReq, 1);
    chk("br_addr", memAddr, 8'h40);
    chk("br_ir_kept", opcode, 5'h11);
    chk("br_pc_kept", pc, 8'h02);
    memAck = 1; memData = 16'h2345;
    step;
    memAck = 0;
    chk("br_fetch_valid", instrValid, 1);
    chk("br_fetch_pc", pc, 8'h40);
    chk("br_fetch_opcode", opcode, 5'b00100);
    chk("br_fetch_rd", rd, 3'b011);
    stall = 1; branchTaken = 1; branchTarget = 8'h10;
    step;
    stall = 0; branchTaken = 0;
    chk("br_stall_valid", instrValid, 0);
    chk("br_stall_addr", memAddr, 8'h10);
    chk("br_stall_req", memReq, 1);
    memAck = 1; memData = 16'hABCD;
    #2 RST = 1;
    #1;
    chk("async_rst_req", memReq, 0);
    chk("async_rst_addr", memAddr, 8'h00);
    chk("async_rst_valid", instrValid, 0);
    chk("async_rst_opcode", opcode, 0);
    chk("async_rst_pc", pc, 8'h00);
    step;
    RST = 0;
    step;
    memAck = 0;
    chk("restart_req", memReq, 1);
    chk("restart_addr", memAddr, 8'h00);
    chk("restart_valid", instrValid, 0);
    chk("restart_opcode", opcode, 0);
    chk("ff_rst_addr", addr1, 8'hFF);
    chk("ff_rst_pc", pc1, 8'hFF);
    rst1 = 0;
    step;
    chk("ff_first_req", req1, 1);
    chk("ff_first_addr", addr1, 8'hFF);
    ack1 = 1; data1 = 16'h1000;
    step;
    ack1 = 0;
    chk("ff_pc0", pc1, 8'hFF);
    chk("ff_valid0", valid1, 1);
    step;
    chk("ff_wrap_addr", addr1, 8'h00);
    chk("ff_wrap_req", req1, 1);
    ack1 = 1; data1 = 16'h5A05;
    step;
    ack1 = 0;
    chk("ff_pc1", pc1, 8'h00);
    chk("ff_opcode1", opcode1, 5'b01011);
    step;
    chk("ff_next_addr", addr1, 8'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
